// File: rtl/fp_int_multiplier.sv
// fp_int_multiplier: radix-2 shift-add 32x32 MULT/MULTU writing a 64-bit product to the FP register file
module fp_int_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   opA,
    input  logic [WIDTH-1:0]   opB,
    input  logic [4:0]         rd,
    input  logic               flush,
    output logic               busy,
    output logic               regWr,
    output logic [4:0]         rW,
    output logic [2*WIDTH-1:0] busW
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, busw_q, busw_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d, mplr_q, mplr_d, mag_a, mag_b;
    logic [CW-1:0]      count_q, count_d;
    logic               sign_q, sign_d, reg_wr_q, reg_wr_d;
    logic [4:0]         rd_q, rd_d, rw_q, rw_d;
    logic [WIDTH:0]     sum;
    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits unsigned
    always_comb begin
        mag_a = (signed_op & opA[WIDTH-1]) ? -opA : opA;
        mag_b = (signed_op & opB[WIDTH-1]) ? -opB : opB;
    end
    // Next-state: accept, one multiplier bit retired per RUN cycle, sign fix-up and write in DONE
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        count_d  = count_q;
        sign_d   = sign_q;
        rd_d     = rd_q;
        reg_wr_d = 1'b0;
        rw_d     = rw_q;
        busw_d   = busw_q;
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mplr_q[0] ? mcand_q : '0};
        case (state_q)
            IDLE: if (start && !flush) begin
                state_d = RUN;
                acc_d   = '0;
                mcand_d = mag_a;
                mplr_d  = mag_b;
                count_d = '0;
                sign_d  = signed_op & (opA[WIDTH-1] ^ opB[WIDTH-1]);
                rd_d    = rd;
            end
            RUN: if (flush) begin
                state_d = IDLE;
            end else begin
                acc_d   = {sum, acc_q[WIDTH-1:1]};
                mplr_d  = mplr_q >> 1;
                count_d = count_q + 1'b1;
                state_d = (count_q == CW'(WIDTH-1)) ? DONE : RUN;
            end
            DONE: begin
                state_d = IDLE;
                if (!flush) begin
                    reg_wr_d = (rd_q != 5'd0);
                    rw_d     = rd_q;
                    busw_d   = sign_q ? -acc_q : acc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            count_q  <= '0;
            sign_q   <= 1'b0;
            rd_q     <= '0;
            reg_wr_q <= 1'b0;
            rw_q     <= '0;
            busw_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            count_q  <= count_d;
            sign_q   <= sign_d;
            rd_q     <= rd_d;
            reg_wr_q <= reg_wr_d;
            rw_q     <= rw_d;
            busw_q   <= busw_d;
        end
    end
    assign busy  = (state_q != IDLE);
    assign regWr = reg_wr_q;
    assign rW    = rw_q;
    assign busW  = busw_q;
endmodule

// File: tb/tb_fp_int_multiplier.sv
// tb_fp_int_multiplier: randomized and directed checks of fp_int_multiplier against an arithmetic model
module tb_fp_int_multiplier;
    logic        clk = 1'b0, reset, start, signed_op, flush;
    logic [31:0] opA, opB;
    logic [4:0]  rd, rW;
    logic        busy, regWr;
    logic [63:0] busW;
    int          n_chk = 0, n_fail = 0;
    int          wr_k[$];
    logic [63:0] wr_w[$];
    logic [4:0]  wr_r[$];
    logic        busy_tr[0:99];
    int          busy_cnt;
    logic [63:0] busw_evt;
    logic [4:0]  rw_evt;

    fp_int_multiplier dut (
        .clk(clk), .reset(reset), .start(start), .signed_op(signed_op), .opA(opA), .opB(opB),
        .rd(rd), .flush(flush), .busy(busy), .regWr(regWr), .rW(rW), .busW(busW)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa = 64'($signed(a));
        longint sb = 64'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        return s ? 64'(sa * sb) : 64'(ua * ub);
    endfunction

    // kind: 0 none, 1 second start at evt, 2 reset at evt, 3 flush at evt, 4 start on first IDLE after write
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                          input int kind, input int evt, input logic s2, input logic [31:0] a2,
                          input logic [31:0] b2, input logic [4:0] r2, input int n);
        wr_k.delete(); wr_w.delete(); wr_r.delete();
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b1; signed_op = s; opA = a; opB = b; rd = r; flush = 1'b0; reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            busy_tr[k] = busy;
            busy_cnt += int'(busy);
            if (k == evt + 1) begin busw_evt = busW; rw_evt = rW; end
            if (regWr) begin wr_k.push_back(k); wr_w.push_back(busW); wr_r.push_back(rW); end
            start = 1'b0; flush = 1'b0; reset = 1'b0;
            signed_op = 1'($urandom); opA = $urandom; opB = $urandom; rd = 5'($urandom);
            if (kind == 1 && k == evt) begin start = 1'b1; signed_op = s2; opA = a2; opB = b2; rd = r2; end
            if (kind == 2 && k == evt) reset = 1'b1;
            if (kind == 3 && k == evt) flush = 1'b1;
            if (kind == 4 && regWr && wr_k.size() == 1) begin
                start = 1'b1; signed_op = s2; opA = a2; opB = b2; rd = r2;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; flush = 1'b0; signed_op = 1'b0; opA = 32'd3; opB = 32'd4; rd = 5'd1;
        repeat (2) @(negedge clk);
        n_chk += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (regWr !== 1'b0) begin n_fail++; $display("FAIL reset_regWr: got %b expected 0", regWr); end
        if (rW !== 5'd0) begin n_fail++; $display("FAIL reset_rW: got %0d expected 0", rW); end
        if (busW !== 64'd0) begin n_fail++; $display("FAIL reset_busW: got %h expected 0", busW); end
        reset = 1'b0; start = 1'b0;
    endtask

    task automatic test_vectors;
        logic        vs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] va[5] = '{32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] vb[5] = '{32'd6, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [4:0]  vr[5] = '{5'd3, 5'd4, 5'd9, 5'd10, 5'd31};
        logic [63:0] vw[5] = '{64'h2A, 64'hFFFFFFFFFFFFFFF1, 64'hFFFFFFFE00000001, 64'h1, 64'h4000000000000000};
        for (int i = 0; i < 5; i++) begin
            run_op(vs[i], va[i], vb[i], vr[i], 0, -5, 1'b0, 0, 0, 0, 50);
            n_chk += 5;
            if (wr_k.size() != 1) begin n_fail++; $display("FAIL vec%0d_writes: got %0d expected 1", i, wr_k.size()); end
            if (busy_cnt != 33) begin n_fail++; $display("FAIL vec%0d_busy_cycles: got %0d expected 33", i, busy_cnt); end
            if ((wr_k.size() > 0 ? wr_k[0] : -1) != 33) begin n_fail++; $display("FAIL vec%0d_latency: got %0d expected 33", i, wr_k.size() > 0 ? wr_k[0] : -1); end
            if ((wr_w.size() > 0 ? wr_w[0] : 64'hx) !== vw[i]) begin n_fail++; $display("FAIL vec%0d_busW: got %h expected %h", i, wr_w.size() > 0 ? wr_w[0] : 64'hx, vw[i]); end
            if ((wr_r.size() > 0 ? wr_r[0] : 5'hx) !== vr[i]) begin n_fail++; $display("FAIL vec%0d_rW: got %0d expected %0d", i, wr_r.size() > 0 ? wr_r[0] : 5'hx, vr[i]); end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            logic s = 1'($urandom);
            logic [31:0] a = $urandom, b = $urandom;
            logic [4:0] r = 5'($urandom_range(1, 31));
            if (i == 0) a = 32'h80000000;
            if (i == 1) b = 32'd0;
            run_op(s, a, b, r, 0, -5, 1'b0, 0, 0, 0, 40);
            n_chk += 2;
            if (wr_k.size() != 1 || wr_k[0] != 33) begin n_fail++; $display("FAIL rand%0d_write: got %0d writes expected 1 at 33", i, wr_k.size()); end
            if ((wr_w.size() > 0 ? wr_w[0] : 64'hx) !== model(s, a, b)) begin n_fail++; $display("FAIL rand%0d_busW s=%b a=%h b=%h: got %h expected %h", i, s, a, b, wr_w.size() > 0 ? wr_w[0] : 64'hx, model(s, a, b)); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a2 = $urandom, b2 = $urandom;
        run_op(1'b1, 32'h80000000, 32'h80000000, 5'd5, 4, -5, 1'b1, a2, b2, 5'd6, 80);
        n_chk += 4;
        if (wr_k.size() != 2) begin n_fail++; $display("FAIL b2b_writes: got %0d expected 2", wr_k.size()); end
        else begin
            if (wr_k[1] - wr_k[0] != 34) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 34", wr_k[1] - wr_k[0]); end
            if (wr_w[0] !== 64'h4000000000000000) begin n_fail++; $display("FAIL b2b_first: got %h expected 4000000000000000", wr_w[0]); end
            if (wr_w[1] !== model(1'b1, a2, b2) || wr_r[1] !== 5'd6) begin n_fail++; $display("FAIL b2b_second: got %h/%0d expected %h/6", wr_w[1], wr_r[1], model(1'b1, a2, b2)); end
        end
    endtask

    task automatic test_start_while_busy;
        run_op(1'b0, 32'd1234, 32'd5678, 5'd7, 1, 5, 1'b1, 32'hDEADBEEF, 32'h12345678, 5'd8, 75);
        n_chk += 2;
        if (wr_k.size() != 1) begin n_fail++; $display("FAIL busy_start_writes: got %0d expected 1", wr_k.size()); end
        if ((wr_w.size() > 0 ? wr_w[0] : 64'hx) !== 64'd7006652) begin n_fail++; $display("FAIL busy_start_busW: got %h expected %h", wr_w.size() > 0 ? wr_w[0] : 64'hx, 64'd7006652); end
    endtask

    task automatic test_rd_zero;
        run_op(1'b0, 32'd9, 32'd9, 5'd0, 0, -5, 1'b0, 0, 0, 0, 50);
        n_chk += 2;
        if (wr_k.size() != 0) begin n_fail++; $display("FAIL rd0_writes: got %0d expected 0", wr_k.size()); end
        if (busy_cnt != 33) begin n_fail++; $display("FAIL rd0_busy_cycles: got %0d expected 33", busy_cnt); end
    endtask

    task automatic test_reset_mid_run;
        run_op(1'b0, 32'd100, 32'd200, 5'd2, 0, -5, 1'b0, 0, 0, 0, 40);
        run_op(1'b0, 32'd11, 32'd13, 5'd12, 2, 10, 1'b0, 0, 0, 0, 52);
        n_chk += 4;
        if (busy_tr[11] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy_tr[11]); end
        if (wr_k.size() != 0) begin n_fail++; $display("FAIL rst_mid_writes: got %0d expected 0", wr_k.size()); end
        if (busw_evt !== 64'd0) begin n_fail++; $display("FAIL rst_mid_busW: got %h expected 0", busw_evt); end
        if (rw_evt !== 5'd0) begin n_fail++; $display("FAIL rst_mid_rW: got %0d expected 0", rw_evt); end
    endtask

    task automatic test_flush;
        run_op(1'b0, 32'd21, 32'd2, 5'd3, 3, 32, 1'b0, 0, 0, 0, 45);
        n_chk += 2;
        if (wr_k.size() != 0) begin n_fail++; $display("FAIL flush_done_writes: got %0d expected 0", wr_k.size()); end
        if (busy_tr[33] !== 1'b0) begin n_fail++; $display("FAIL flush_done_busy: got %b expected 0", busy_tr[33]); end
        run_op(1'b1, 32'hFFFFFFFF, 32'd2, 5'd3, 3, 15, 1'b0, 0, 0, 0, 45);
        n_chk += 2;
        if (wr_k.size() != 0) begin n_fail++; $display("FAIL flush_run_writes: got %0d expected 0", wr_k.size()); end
        if (busy_tr[16] !== 1'b0) begin n_fail++; $display("FAIL flush_run_busy: got %b expected 0", busy_tr[16]); end
        @(negedge clk);
        start = 1'b1; flush = 1'b1; opA = 32'd5; opB = 32'd5; rd = 5'd4; signed_op = 1'b0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b expected 0", busy); end
        begin
            int seen = 0;
            for (int k = 0; k < 40; k++) begin seen += int'(regWr); @(negedge clk); end
            n_chk++;
            if (seen != 0) begin n_fail++; $display("FAIL flush_start_writes: got %0d expected 0", seen); end
        end
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_random;
        test_back_to_back;
        test_start_while_busy;
        test_rd_zero;
        test_reset_mid_run;
        test_flush;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
